// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: lock/request inputs and staged reset outputs of the reset sequencer.
interface reset_sequencer_if #(
    parameter int STAGES = 3
);
    logic              locked;
    logic              req_reset;
    logic [STAGES-1:0] rst_out;
    logic              done;
    logic              lock_err;
    modport master (output locked, req_reset, input rst_out, done, lock_err);
    modport slave  (input locked, req_reset, output rst_out, done, lock_err);
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered release of STAGES resets after hold time and lock.
// Optional lock watchdog enabled by defining RESET_SEQ_WDT_EN.
module reset_sequencer #(
    parameter int STAGES      = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8,
    parameter int WDT_CYCLES  = 1024
) (
    input logic              clk,
    input logic              rst,
    reset_sequencer_if.slave bus
);
    localparam int HS   = HOLD_CYCLES > STEP_CYCLES ? HOLD_CYCLES : STEP_CYCLES;
    localparam int MAXC = HS > WDT_CYCLES ? HS : WDT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(STAGES + 1);
    typedef enum logic [1:0] {HOLD, WAIT_LOCK, RELEASE, RUN} state_t;
    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic [STAGES-1:0] rst_out_q;
    logic              done_q;
    logic              sync1_q;
    logic              lock_s_q;
    logic              restart;
    // Lock loss only matters once release has begun; WAIT_LOCK just keeps waiting.
    assign restart = (bus.req_reset && state_q != HOLD) ||
                     (!lock_s_q && (state_q == RELEASE || state_q == RUN));
    assign bus.rst_out = rst_out_q;
    assign bus.done    = done_q;
`ifdef RESET_SEQ_WDT_EN
    logic [CW-1:0] wdt_q;
    logic          lock_err_q;
    assign bus.lock_err = lock_err_q;
`else
    assign bus.lock_err = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            rst_out_q  <= '1;
            done_q     <= 1'b0;
            sync1_q    <= 1'b0;
            lock_s_q   <= 1'b0;
`ifdef RESET_SEQ_WDT_EN
            wdt_q      <= '0;
            lock_err_q <= 1'b0;
`endif
        end else begin
            sync1_q  <= bus.locked;
            lock_s_q <= sync1_q;
            if (restart) begin
                state_q   <= HOLD;
                cnt_q     <= '0;
                idx_q     <= '0;
                rst_out_q <= '1;
                done_q    <= 1'b0;
`ifdef RESET_SEQ_WDT_EN
                wdt_q     <= '0;
`endif
            end else begin
                case (state_q)
                    HOLD: begin
                        if (bus.req_reset) begin
                            cnt_q <= '0;
                        end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                            cnt_q   <= '0;
                            state_q <= WAIT_LOCK;
`ifdef RESET_SEQ_WDT_EN
                            wdt_q   <= '0;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_s_q) begin
                            state_q <= RELEASE;
                            cnt_q   <= '0;
                            idx_q   <= '0;
`ifdef RESET_SEQ_WDT_EN
                        end else if (wdt_q == CW'(WDT_CYCLES - 1)) begin
                            lock_err_q <= 1'b1;
                            state_q    <= HOLD;
                            cnt_q      <= '0;
                        end else begin
                            wdt_q <= wdt_q + 1'b1;
`endif
                        end
                    end
                    RELEASE: begin
                        if (cnt_q == CW'(STEP_CYCLES - 1)) begin
                            rst_out_q[idx_q] <= 1'b0;
                            cnt_q            <= '0;
                            idx_q            <= idx_q + 1'b1;
                            if (idx_q == IW'(STAGES - 1)) begin
                                state_q <= RUN;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench; expectations keyed by edge count since rst fell.
module tb_reset_sequencer;
    typedef struct {
        int         cyc;
        logic [2:0] ro;
        logic       dn;
        logic       le;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t e;
`ifdef RESET_SEQ_WDT_EN
    localparam logic WDT = 1'b1;
`else
    localparam logic WDT = 1'b0;
`endif
    reset_sequencer_if #(.STAGES(3)) sif ();
    reset_sequencer #(.STAGES(3), .HOLD_CYCLES(16), .STEP_CYCLES(8), .WDT_CYCLES(64)) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );
    always #5 clk = ~clk;
    always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check($sformatf("rst_out@%0d", e.cyc), 32'(sif.rst_out), 32'(e.ro));
            check($sformatf("done@%0d", e.cyc), 32'(sif.done), 32'(e.dn));
            check($sformatf("lock_err@%0d", e.cyc), 32'(sif.lock_err), 32'(e.le));
        end
    end
    task automatic push(input int c, input logic [2:0] ro, input logic dn, input logic le);
        sb.push_back('{c, ro, dn, le});
    endtask
    task automatic do_reset(input logic lk);
        rst = 1'b1;
        sif.locked = lk;
        sif.req_reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rst_out", 32'(sif.rst_out), 32'h7);
        check("reset done", 32'(sif.done), 32'h0);
        check("reset lock_err", 32'(sif.lock_err), 32'h0);
        rst = 1'b0;
    endtask
    task automatic wait_cyc(input int n);
        for (int i = 0; i < 2000 && cyc != n; i++) @(negedge clk);
        if (cyc != n) check($sformatf("wait cyc %0d", n), 32'(cyc), 32'(n));
    endtask
    task automatic drain();
        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'h0);
        sb.delete();
    endtask
    initial begin
        sif.locked = 1'b0;
        sif.req_reset = 1'b0;
        // Lock held throughout: releases at 25/33/41.
        do_reset(1'b1);
        push(1, 3'b111, 0, 0); push(16, 3'b111, 0, 0); push(24, 3'b111, 0, 0);
        push(25, 3'b110, 0, 0); push(32, 3'b110, 0, 0); push(33, 3'b100, 0, 0);
        push(40, 3'b100, 0, 0); push(41, 3'b000, 1, 0); push(50, 3'b000, 1, 0);
        drain();
        // Late lock: captured at edge 100, first release at 110.
        do_reset(1'b0);
        push(50, 3'b111, 0, 0); push(109, 3'b111, 0, 0); push(110, 3'b110, 0, 0);
        wait_cyc(99);
        sif.locked = 1'b1;
        drain();
        // Lock loss in RUN, then relock repeats the full sequence.
        do_reset(1'b1);
        push(41, 3'b000, 1, 0); push(47, 3'b000, 1, 0); push(48, 3'b111, 0, 0);
        push(72, 3'b111, 0, 0); push(73, 3'b110, 0, 0); push(81, 3'b100, 0, 0);
        push(88, 3'b100, 0, 0); push(89, 3'b000, 1, 0);
        wait_cyc(45);
        sif.locked = 1'b0;
        wait_cyc(60);
        sif.locked = 1'b1;
        drain();
        // Request during HOLD restarts the hold count.
        do_reset(1'b1);
        push(26, 3'b111, 0, 0); push(34, 3'b111, 0, 0); push(35, 3'b110, 0, 0);
        push(50, 3'b100, 0, 0); push(51, 3'b000, 1, 0);
        wait_cyc(9);
        sif.req_reset = 1'b1;
        wait_cyc(10);
        sif.req_reset = 1'b0;
        drain();
        // Request on the final release edge wins over the release.
        do_reset(1'b1);
        push(40, 3'b100, 0, 0); push(41, 3'b111, 0, 0); push(42, 3'b111, 0, 0);
        push(65, 3'b111, 0, 0); push(66, 3'b110, 0, 0); push(82, 3'b000, 1, 0);
        wait_cyc(40);
        sif.req_reset = 1'b1;
        wait_cyc(41);
        sif.req_reset = 1'b0;
        drain();
        // Asynchronous rst mid-RELEASE acts before the next clock edge.
        do_reset(1'b1);
        push(25, 3'b110, 0, 0);
        wait_cyc(30);
        #1 rst = 1'b1;
        #1;
        check("async rst_out", 32'(sif.rst_out), 32'h7);
        check("async done", 32'(sif.done), 32'h0);
        drain();
        do_reset(1'b1);
        push(24, 3'b111, 0, 0); push(25, 3'b110, 0, 0); push(41, 3'b000, 1, 0);
        drain();
        // No lock: watchdog retry when enabled, indefinite wait otherwise.
        do_reset(1'b0);
        push(79, 3'b111, 0, 0); push(80, 3'b111, 0, WDT);
        if (WDT) begin
            push(104, 3'b111, 0, 1); push(105, 3'b110, 0, 1); push(121, 3'b000, 1, 1);
        end else begin
            push(95, 3'b111, 0, 0); push(96, 3'b110, 0, 0); push(112, 3'b000, 1, 0);
        end
        wait_cyc(85);
        sif.locked = 1'b1;
        drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL global timeout: cyc %0d expected completion", cyc);
        $fatal(1);
    end
endmodule
